// File: rtl/rc_buff.sv
// rc_buff: write-side pixel buffer. Queues producer pixel writes in a small FIFO
// and commits them to SRAM through the start/ready/rw controller handshake.
module rc_buff #(
  parameter int addr_bus_size = 16,
  parameter int data_bus_size = 16,
  parameter int fifo_aw       = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [16:0]              wr_addr,
  input  logic [11:0]              wr_pixel,
  output logic                     wr_ready,
  input  logic                     ready,
  output logic [addr_bus_size-1:0] sram_addr,
  output logic [data_bus_size-1:0] sram_data,
  output logic                     start,
  output logic                     rw,
  output logic [fifo_aw:0]         fifo_count,
  output logic                     busy,
  output logic                     overflow
);

  localparam int depth_c = 1 << fifo_aw;
  localparam int entry_w_c = addr_bus_size + 12;
  localparam logic [fifo_aw:0]   cnt_full_c = {1'b1, {fifo_aw{1'b0}}};
  localparam logic [fifo_aw:0]   cnt_one_c  = {{fifo_aw{1'b0}}, 1'b1};
  localparam logic [fifo_aw:0]   cnt_zero_c = {(fifo_aw + 1){1'b0}};
  localparam logic [fifo_aw-1:0] ptr_one_c  = {{(fifo_aw - 1){1'b0}}, 1'b1};
  localparam logic [fifo_aw-1:0] ptr_zero_c = {fifo_aw{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    HOLD  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t                     state_r;
  state_t                     state_nxt_s;
  logic [entry_w_c-1:0]       mem_r [depth_c];
  logic [fifo_aw-1:0]         wr_ptr_r;
  logic [fifo_aw-1:0]         rd_ptr_r;
  logic [fifo_aw:0]           count_r;
  logic                       overflow_r;
  logic                       start_r;
  logic                       start_nxt_s;
  logic                       load_s;
  logic [addr_bus_size-1:0]   sram_addr_r;
  logic [data_bus_size-1:0]   sram_data_r;
  logic                       wr_ready_s;
  logic                       fifo_empty_s;
  logic                       push_s;
  logic                       pop_s;
  logic [entry_w_c-1:0]       head_s;

  assign wr_ready_s   = (count_r != cnt_full_c);
  assign fifo_empty_s = (count_r == cnt_zero_c);
  // Out-of-range beats (flag bit set) are accepted but never stored.
  assign push_s       = wr_valid && wr_ready_s && !wr_addr[16];
  assign pop_s        = load_s;
  assign head_s       = mem_r[rd_ptr_r];

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {wr_addr[addr_bus_size-1:0], wr_pixel};
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= ptr_zero_c;
      rd_ptr_r   <= ptr_zero_c;
      count_r    <= cnt_zero_c;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ptr_one_c;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_one_c;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + cnt_one_c;
        2'b01:   count_r <= count_r - cnt_one_c;
        default: count_r <= count_r;
      endcase
      if (wr_valid && !wr_ready_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Write-engine state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Write-engine next-state logic; HOLD deliberately ignores ready while the controller settles
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (fifo_empty_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = START;
        end
      end
      START:   state_nxt_s = HOLD;
      HOLD:    state_nxt_s = WAIT;
      WAIT: begin
        if (ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Write-engine output decode: load head and strobe start only when leaving IDLE
  always_comb begin
    load_s      = 1'b0;
    start_nxt_s = 1'b1;
    case (state_r)
      IDLE: begin
        if (fifo_empty_s) begin
          load_s      = 1'b0;
          start_nxt_s = 1'b1;
        end else begin
          load_s      = 1'b1;
          start_nxt_s = 1'b0;
        end
      end
      START: begin
        load_s      = 1'b0;
        start_nxt_s = 1'b1;
      end
      HOLD: begin
        load_s      = 1'b0;
        start_nxt_s = 1'b1;
      end
      WAIT: begin
        load_s      = 1'b0;
        start_nxt_s = 1'b1;
      end
      default: begin
        load_s      = 1'b0;
        start_nxt_s = 1'b1;
      end
    endcase
  end

  // Registered SRAM request: address/data held from the strobe until the next load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_r     <= 1'b1;
      sram_addr_r <= {addr_bus_size{1'b0}};
      sram_data_r <= {data_bus_size{1'b0}};
    end else begin
      start_r <= start_nxt_s;
      if (load_s) begin
        sram_addr_r <= head_s[entry_w_c-1:12];
        sram_data_r <= {{(data_bus_size - 12){1'b0}}, head_s[11:0]};
      end
    end
  end

  assign wr_ready   = wr_ready_s;
  assign sram_addr  = sram_addr_r;
  assign sram_data  = sram_data_r;
  assign start      = start_r;
  assign rw         = 1'b0;
  assign fifo_count = count_r;
  assign busy       = !fifo_empty_s || (state_r != IDLE);
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_rc_buff.sv
// Randomized self-checking bench for rc_buff against a queue-based model of
// the write buffer and its per-write SRAM timing.
module tb_rc_buff;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic [16:0] wr_addr;
  logic [11:0] wr_pixel;
  logic        wr_ready;
  logic        ready;
  logic [15:0] sram_addr;
  logic [15:0] sram_data;
  logic        start;
  logic        rw;
  logic [3:0]  fifo_count;
  logic        busy;
  logic        overflow;

  rc_buff #(.addr_bus_size(16), .data_bus_size(16), .fifo_aw(3)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_pixel(wr_pixel), .wr_ready(wr_ready), .ready(ready),
    .sram_addr(sram_addr), .sram_data(sram_data), .start(start), .rw(rw),
    .fifo_count(fifo_count), .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: queue of pending {addr,pixel}; one write in flight occupies the
  // engine for a strobe cycle, a settle cycle, then until ready is seen.
  logic [27:0] m_q[$];
  logic [15:0] m_issue_q[$];
  bit          m_eng;
  int          m_age;
  logic [15:0] m_addr;
  logic [15:0] m_data;
  bit          m_ovf;
  bit          m_acc;
  bit          rdy_rand;
  int          start_pulses;

  task automatic model_reset();
    m_q.delete();
    m_issue_q.delete();
    m_eng  = 1'b0;
    m_age  = 0;
    m_addr = 16'h0;
    m_data = 16'h0;
    m_ovf  = 1'b0;
    m_acc  = 1'b0;
  endtask

  task automatic model_edge();
    int pre;
    logic [27:0] e;
    pre   = m_q.size();
    m_acc = 1'b0;
    if (m_eng) begin
      if (m_age >= 2 && ready) m_eng = 1'b0;
      else m_age++;
    end else if (pre != 0) begin
      e = m_q.pop_front();
      m_addr = e[27:12];
      m_data = {4'h0, e[11:0]};
      m_issue_q.push_back(e[27:12]);
      m_eng = 1'b1;
      m_age = 0;
    end
    if (wr_valid) begin
      if (pre < DEPTH) begin
        m_acc = 1'b1;
        if (!wr_addr[16]) m_q.push_back({wr_addr[15:0], wr_pixel});
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check_val("start", 32'(start), 32'(!(m_eng && m_age == 0)));
    check_val("sram_addr", 32'(sram_addr), 32'(m_addr));
    check_val("sram_data", 32'(sram_data), 32'(m_data));
    check_val("rw", 32'(rw), 32'd0);
    check_val("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check_val("wr_ready", 32'(wr_ready), 32'(m_q.size() < DEPTH));
    check_val("busy", 32'(busy), 32'((m_q.size() != 0) || m_eng));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    if (start === 1'b0) begin
      start_pulses++;
      if (m_issue_q.size() == 0) check_val("stray_start", 32'(start), 32'd1);
      else check_val("issue_order", 32'(sram_addr), 32'(m_issue_q.pop_front()));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    else m_acc = 1'b0;
    @(negedge clk);
    check_all();
    if (rdy_rand) ready = ($urandom_range(0, 2) == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [16:0] a, input logic [11:0] p);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_pixel = p;
    for (int k = 0; k < 200; k++) begin
      step();
      if (m_acc) break;
    end
    wr_valid = 1'b0;
    if (!m_acc) check_val("send_timeout", 32'(wr_ready), 32'd1);
  endtask

  int p0;

  initial begin
    reset = 1'b0; wr_valid = 1'b0; wr_addr = 17'h0; wr_pixel = 12'h0;
    ready = 1'b1; rdy_rand = 1'b0; start_pulses = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    check_val("rst_start", 32'(start), 32'd1);
    check_val("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    idle(2);

    // Single in-range push with ready high
    send(17'h00012, 12'hABC);
    step();
    check_val("t2_start_low", 32'(start), 32'd0);
    check_val("t2_addr", 32'(sram_addr), 32'h0012);
    check_val("t2_data", 32'(sram_data), 32'h0ABC);
    step();
    check_val("t2_start_high", 32'(start), 32'd1);
    step();
    check_val("t2_busy_hold", 32'(busy), 32'd1);
    step();
    check_val("t2_busy_drop", 32'(busy), 32'd0);
    idle(2);

    // Out-of-range beat is consumed and dropped
    p0 = start_pulses;
    send(17'h10005, 12'h123);
    check_val("t3_count", 32'(fifo_count), 32'd0);
    check_val("t3_ready", 32'(wr_ready), 32'd1);
    idle(6);
    check_val("t3_no_start", 32'(start_pulses - p0), 32'd0);

    // Fill with ready held low, then overflow, then drain
    ready = 1'b0;
    p0 = start_pulses;
    for (int i = 0; i < 9; i++) send(17'(i), 12'(12'h100 + i));
    check_val("t4_full_count", 32'(fifo_count), 32'd8);
    check_val("t4_full_ready", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1; wr_addr = 17'd9; wr_pixel = 12'h109;
    step();
    wr_valid = 1'b0;
    check_val("t4_overflow", 32'(overflow), 32'd1);
    check_val("t4_count_hold", 32'(fifo_count), 32'd8);
    ready = 1'b1;
    idle(50);
    check_val("t4_pulses", 32'(start_pulses - p0), 32'd9);

    // Push and pop on the same edge with three queued
    ready = 1'b0;
    for (int i = 0; i < 4; i++) send(17'(17'h20 + i), 12'(12'h200 + i));
    check_val("t5_pre_count", 32'(fifo_count), 32'd3);
    ready = 1'b1;
    step();
    wr_valid = 1'b1; wr_addr = 17'h24; wr_pixel = 12'h224;
    step();
    wr_valid = 1'b0;
    check_val("t5_pushpop_count", 32'(fifo_count), 32'd3);
    check_val("t5_pushpop_start", 32'(start), 32'd0);
    idle(30);

    // Twenty beats across pointer wrap with random ready latency
    rdy_rand = 1'b1;
    p0 = start_pulses;
    for (int i = 0; i < 20; i++) send(17'(i), 12'($urandom));
    idle(150);
    check_val("t5_wrap_pulses", 32'(start_pulses - p0), 32'd20);

    // Free-running random traffic; producer holds a refused beat
    for (int c = 0; c < 400; c++) begin
      if (!wr_valid || m_acc) begin
        wr_valid = ($urandom_range(0, 3) != 0);
        wr_addr  = {($urandom_range(0, 7) == 0), 16'($urandom)};
        wr_pixel = 12'($urandom);
      end
      step();
    end
    wr_valid = 1'b0;
    rdy_rand = 1'b0;
    ready = 1'b1;
    idle(60);

    // Asynchronous reset while waiting on the controller with five queued
    ready = 1'b0;
    for (int i = 0; i < 6; i++) send(17'(17'h40 + i), 12'(12'h400 + i));
    check_val("t6_pre_count", 32'(fifo_count), 32'd5);
    check_val("t6_pre_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_val("t6_rst_start", 32'(start), 32'd1);
    check_val("t6_rst_count", 32'(fifo_count), 32'd0);
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    check_val("t6_rst_ovf", 32'(overflow), 32'd0);
    model_reset();
    idle(2);
    reset = 1'b1;
    ready = 1'b1;
    p0 = start_pulses;
    idle(20);
    check_val("t6_no_stale", 32'(start_pulses - p0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
